// File: rtl/draw_sequencer_pkg.sv
// Shared types and defaults for the frame scheduler / pixel arbiter.
// Layer order: 0 = ball, 1 = bricks, 2 = platform.
package draw_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_E_GO,
      S_E_WAIT,
      S_L_GO,
      S_L_WAIT,
      S_INC,
      S_D_GO,
      S_D_WAIT
   } seq_state_t;

   localparam int DEF_NUM_LAYERS   = 3;
   localparam int DEF_COORD_W      = 10;
   localparam int DEF_COLOUR_W     = 3;
   localparam int DEF_CNT_W        = 20;
   localparam int DEF_ERASE_COLOUR = 0;
   localparam int DEF_LOGIC_WAIT   = 30;

`ifndef BRICKDRAWTWO
`define BRICKDRAWTWO 0
`endif

   // A budget of 0 means the slot waits for the layer's done pulse only.
   localparam int BUDGET_BALL     = 4;
   localparam int BUDGET_BRICKS   = `BRICKDRAWTWO;
   localparam int BUDGET_PLATFORM = 30;

   // Lowest set bit of mask at or above position from, or -1 when none.
   function automatic int lowest_set_from(input logic [31:0] mask, input int from, input int n);
      int r;
      r = -1;
      for (int i = n - 1; i >= 0; i--) begin
         if (mask[i] && i >= from) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Layer handshake, overlay pixel and VGA pixel bundle between the sequencer
// (master) and the drawing layers / adapter (slave).
interface draw_sequencer_if
   import draw_sequencer_pkg::*;
#(
   parameter int NUM_LAYERS = DEF_NUM_LAYERS,
   parameter int COORD_W    = DEF_COORD_W,
   parameter int COLOUR_W   = DEF_COLOUR_W,
   parameter int CNT_W      = DEF_CNT_W
);
   logic [NUM_LAYERS*COORD_W-1:0]  layer_x;
   logic [NUM_LAYERS*COORD_W-1:0]  layer_y;
   logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour;
   logic [NUM_LAYERS-1:0]          layer_plot;
   logic [NUM_LAYERS-1:0]          layer_done;
   logic [NUM_LAYERS*CNT_W-1:0]    layer_budget;
   logic [NUM_LAYERS-1:0]          layer_go;

   logic                           overlay_en;
   logic [COORD_W-1:0]             overlay_x;
   logic [COORD_W-1:0]             overlay_y;
   logic [COLOUR_W-1:0]            overlay_colour;
   logic                           overlay_plot;

   logic [COORD_W-1:0]             vga_x;
   logic [COORD_W-1:0]             vga_y;
   logic [COLOUR_W-1:0]            vga_colour;
   logic                           vga_plot;

   modport master (
      input  layer_x, layer_y, layer_colour, layer_plot, layer_done, layer_budget,
      input  overlay_en, overlay_x, overlay_y, overlay_colour, overlay_plot,
      output layer_go,
      output vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      output layer_x, layer_y, layer_colour, layer_plot, layer_done, layer_budget,
      output overlay_en, overlay_x, overlay_y, overlay_colour, overlay_plot,
      input  layer_go,
      input  vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/draw_sequencer_slot_timer.sv
// Per-slot cycle counter: a slot ends on done or when the budget is used up.
module slot_timer
   import draw_sequencer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             active,
   input  logic             done,
   input  logic [CNT_W-1:0] budget,
   output logic             slot_exit
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg <= '0;
      end else if (start) begin
         cnt_reg <= '0;
      end else if (active) begin
         cnt_reg <= cnt_reg + ONE;
      end
   end

   // Done and expiry in the same cycle collapse into one exit.
   assign slot_exit = active && (done || ((budget != '0) && ((cnt_reg + ONE) == budget)));

endmodule

// File: rtl/draw_sequencer.sv
// Frame scheduler: erase pass, logic window, position increment, colour pass,
// with an overlay-priority registered pixel port to the VGA adapter.
module draw_sequencer
   import draw_sequencer_pkg::*;
#(
   parameter int                    NUM_LAYERS   = DEF_NUM_LAYERS,
   parameter int                    COORD_W      = DEF_COORD_W,
   parameter int                    COLOUR_W     = DEF_COLOUR_W,
   parameter int                    CNT_W        = DEF_CNT_W,
   parameter logic [NUM_LAYERS-1:0] ERASE_MASK   = 3'b101,
   parameter logic [COLOUR_W-1:0]   ERASE_COLOUR = COLOUR_W'(DEF_ERASE_COLOUR),
   parameter int                    LOGIC_WAIT   = DEF_LOGIC_WAIT
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             frame_tick,
   draw_sequencer_if.master bus,
   output logic             logic_go,
   output logic             inc_enable,
   output logic             erase_phase,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
);
   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [31:0] MASK32 = 32'(ERASE_MASK);
   localparam int FIRST_ERASE = lowest_set_from(MASK32, 0, NUM_LAYERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

   seq_state_t       state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             pending_reg;

   logic [COORD_W-1:0]  lx [NUM_LAYERS];
   logic [COORD_W-1:0]  ly [NUM_LAYERS];
   logic [COLOUR_W-1:0] lc [NUM_LAYERS];
   logic [CNT_W-1:0]    lb [NUM_LAYERS];

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_unpack
         assign lx[gi] = bus.layer_x[gi*COORD_W +: COORD_W];
         assign ly[gi] = bus.layer_y[gi*COORD_W +: COORD_W];
         assign lc[gi] = bus.layer_colour[gi*COLOUR_W +: COLOUR_W];
         assign lb[gi] = bus.layer_budget[gi*CNT_W +: CNT_W];
      end
   endgenerate

   logic                  in_go;
   logic                  in_wait;
   logic                  slot_start;
   logic                  slot_active;
   logic                  slot_done;
   logic                  slot_exit;
   logic [CNT_W-1:0]      slot_budget;
   logic [NUM_LAYERS-1:0] layer_go_vec;
   int                    next_erase;

   always_comb begin
      in_go        = (state_reg == S_E_GO) || (state_reg == S_D_GO);
      in_wait      = (state_reg == S_E_WAIT) || (state_reg == S_D_WAIT);
      slot_start   = in_go || (state_reg == S_L_GO);
      slot_active  = in_wait || (state_reg == S_L_WAIT);
      // Only the done of the layer currently being served can end its slot.
      slot_done    = in_wait && bus.layer_done[idx_reg];
      // The logic window reuses the slot timer with a fixed budget.
      slot_budget  = (state_reg == S_L_WAIT) ? CNT_W'(LOGIC_WAIT) : lb[idx_reg];
      next_erase   = lowest_set_from(MASK32, int'(idx_reg) + 1, NUM_LAYERS);
   end

   slot_timer #(.CNT_W(CNT_W)) u_slot_timer (
      .clk       (clk),
      .resetn    (resetn),
      .start     (slot_start),
      .active    (slot_active),
      .done      (slot_done),
      .budget    (slot_budget),
      .slot_exit (slot_exit)
   );

   always_comb begin
      layer_go_vec = '0;
      if (in_go) layer_go_vec[idx_reg] = 1'b1;
      logic_go     = (state_reg == S_L_GO);
      inc_enable   = (state_reg == S_INC);
      erase_phase  = (state_reg == S_E_GO) || (state_reg == S_E_WAIT);
      busy         = (state_reg != S_IDLE);
   end

   assign bus.layer_go = layer_go_vec;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= S_IDLE;
         idx_reg     <= '0;
         pending_reg <= 1'b0;
         overrun     <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_tick) begin
            pending_reg <= 1'b1;
            if (pending_reg) overrun <= 1'b1;
         end
         // Overlay takes the screen: drop the frame without completing it.
         if ((state_reg != S_IDLE) && bus.overlay_en) begin
            state_reg   <= S_IDLE;
            pending_reg <= 1'b0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if ((pending_reg || frame_tick) && !bus.overlay_en) begin
                     pending_reg <= 1'b0;
                     if (ERASE_MASK != '0) begin
                        idx_reg   <= IDX_W'(FIRST_ERASE);
                        state_reg <= S_E_GO;
                     end else begin
                        state_reg <= S_L_GO;
                     end
                  end
               end
               S_E_GO:   state_reg <= S_E_WAIT;
               S_E_WAIT: begin
                  if (slot_exit) begin
                     if (next_erase >= 0) begin
                        idx_reg   <= IDX_W'(next_erase);
                        state_reg <= S_E_GO;
                     end else begin
                        state_reg <= S_L_GO;
                     end
                  end
               end
               S_L_GO:   state_reg <= S_L_WAIT;
               S_L_WAIT: if (slot_exit) state_reg <= S_INC;
               S_INC: begin
                  idx_reg   <= '0;
                  state_reg <= S_D_GO;
               end
               S_D_GO:   state_reg <= S_D_WAIT;
               S_D_WAIT: begin
                  if (slot_exit) begin
                     if (idx_reg == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state_reg  <= S_IDLE;
                     end else begin
                        idx_reg   <= idx_reg + IDX_W'(1);
                        state_reg <= S_D_GO;
                     end
                  end
               end
               default:  state_reg <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
      end else if (bus.overlay_en) begin
         bus.vga_x      <= bus.overlay_x;
         bus.vga_y      <= bus.overlay_y;
         bus.vga_colour <= bus.overlay_colour;
         bus.vga_plot   <= bus.overlay_plot;
      end else if (in_go || in_wait) begin
         bus.vga_x      <= lx[idx_reg];
         bus.vga_y      <= ly[idx_reg];
         bus.vga_colour <= erase_phase ? ERASE_COLOUR : lc[idx_reg];
         bus.vga_plot   <= bus.layer_plot[idx_reg];
      end else begin
         bus.vga_plot   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: slot ordering/lengths, pixel arbitration,
// overlay abort, tick overrun and asynchronous reset.
module tb_draw_sequencer;
   localparam int NL = 3;
   localparam int CW = 10;
   localparam int KW = 3;
   localparam int BW = 20;
   localparam int LW = 30;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic frame_tick = 1'b0;
   logic logic_go, inc_enable, erase_phase, busy, frame_done, overrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fd_count = 0;

   draw_sequencer_if #(.NUM_LAYERS(NL), .COORD_W(CW), .COLOUR_W(KW), .CNT_W(BW)) bus ();

   draw_sequencer #(
      .NUM_LAYERS(NL), .COORD_W(CW), .COLOUR_W(KW), .CNT_W(BW),
      .ERASE_MASK(3'b101), .ERASE_COLOUR(3'b000), .LOGIC_WAIT(LW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .frame_tick  (frame_tick),
      .bus         (bus),
      .logic_go    (logic_go),
      .inc_enable  (inc_enable),
      .erase_phase (erase_phase),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (frame_done) fd_count <= fd_count + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // {layer_go[2:0], logic_go, inc_enable}
   function automatic logic [4:0] evt();
      return {bus.layer_go, logic_go, inc_enable};
   endfunction

   task automatic wait_pat(input logic [4:0] target, input int bound, output int ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (evt() === target) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_fd(input int bound, output int ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   initial begin
      int ok, t, fd0, seen;
      bus.layer_x        = {10'd300, 10'd200, 10'd17};
      bus.layer_y        = {10'd30, 10'd20, 10'd7};
      bus.layer_colour   = {3'b011, 3'b010, 3'b110};
      bus.layer_plot     = 3'b111;
      bus.layer_done     = 3'b000;
      bus.layer_budget   = {20'd30, 20'd0, 20'd4};
      bus.overlay_en     = 1'b0;
      bus.overlay_x      = '0;
      bus.overlay_y      = '0;
      bus.overlay_colour = '0;
      bus.overlay_plot   = 1'b0;

      // ---- reset ----
      #2 resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("reset_ctrl", 32'({bus.layer_go, logic_go, inc_enable, erase_phase, busy, frame_done, overrun}), 32'd0);
      chk("reset_pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 32'd0);
      $display("tb: reset checked at cycle %0d", cyc);

      // ---- single frame: order, slot lengths, erase colour ----
      frame_tick = 1'b1;
      t = cyc;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("erase_go0", 32'(evt()), 32'b00100);
      chk("tick_to_go", cyc - t, 1);
      chk("erase_phase_on", 32'(erase_phase), 32'd1);
      t = cyc;
      @(negedge clk);
      chk("erase_colour", 32'(bus.vga_colour), 32'd0);
      chk("erase_plot", 32'(bus.vga_plot), 32'd1);
      chk("erase_x", 32'(bus.vga_x), 32'd17);
      wait_pat(5'b10000, 40, ok);
      chk("erase_go2_seen", ok, 1);
      chk("erase_slot0_len", cyc - t, 5);
      t = cyc;
      wait_pat(5'b00010, 60, ok);
      chk("logic_go_seen", ok, 1);
      chk("erase_slot2_len", cyc - t, 31);
      t = cyc;
      wait_pat(5'b00001, 60, ok);
      chk("inc_seen", ok, 1);
      chk("logic_window_len", cyc - t, 31);
      chk("inc_plot_off", 32'(bus.vga_plot), 32'd0);
      wait_pat(5'b00100, 5, ok);
      chk("draw_go0_seen", ok, 1);
      chk("draw_erase_phase_off", 32'(erase_phase), 32'd0);
      t = cyc;
      @(negedge clk);
      chk("draw_colour", 32'(bus.vga_colour), 32'b110);
      chk("draw_x", 32'(bus.vga_x), 32'd17);
      wait_pat(5'b01000, 10, ok);
      chk("draw_go1_seen", ok, 1);
      chk("draw_slot0_len", cyc - t, 5);
      t = cyc;
      repeat (5) @(negedge clk);
      bus.layer_done = 3'b010;
      @(negedge clk);
      bus.layer_done = 3'b000;
      chk("draw_go2_after_done", 32'(evt()), 32'b10000);
      chk("draw_slot1_len", cyc - t, 6);
      t = cyc;
      repeat (2) @(negedge clk);
      bus.layer_done = 3'b001;
      @(negedge clk);
      bus.layer_done = 3'b000;
      fd0 = fd_count;
      wait_fd(40, ok);
      chk("frame_done_seen", ok, 1);
      chk("draw_slot2_len", cyc - t, 31);
      chk("idle_after_frame", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("frame_done_once", fd_count - fd0, 1);
      chk("stay_idle", 32'({busy, bus.layer_go}), 32'd0);
      $display("tb: single frame done at cycle %0d", cyc);

      // ---- done coinciding with budget expiry ----
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("coincide_go0", 32'(evt()), 32'b00100);
      t = cyc;
      repeat (4) @(negedge clk);
      bus.layer_done = 3'b001;
      @(negedge clk);
      bus.layer_done = 3'b000;
      chk("coincide_next_go", 32'(evt()), 32'b10000);
      chk("coincide_gap", cyc - t, 5);
      @(negedge clk);
      chk("coincide_single_advance", 32'(evt()), 32'd0);
      chk("coincide_still_erase", 32'(erase_phase), 32'd1);
      $display("tb: coincident exit checked at cycle %0d", cyc);

      // ---- overlay abort mid D_WAIT ----
      wait_pat(5'b01000, 120, ok);
      chk("overlay_reach_draw_go1", ok, 1);
      repeat (3) @(negedge clk);
      fd0 = fd_count;
      bus.overlay_en     = 1'b1;
      bus.overlay_x      = 10'd123;
      bus.overlay_y      = 10'd45;
      bus.overlay_colour = 3'b101;
      bus.overlay_plot   = 1'b1;
      @(negedge clk);
      chk("overlay_pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}),
          32'({10'd123, 10'd45, 3'b101, 1'b1}));
      chk("overlay_abort_idle", 32'(busy), 32'd0);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy !== 1'b0 || bus.layer_go !== 3'b000) seen = 1;
      end
      chk("no_frame_under_overlay", seen, 0);
      chk("no_frame_done_on_abort", fd_count - fd0, 0);
      bus.overlay_en = 1'b0;
      @(negedge clk);
      chk("pending_start_after_overlay", 32'(evt()), 32'b00100);
      chk("pixel_hold_x", 32'(bus.vga_x), 32'd123);
      chk("pixel_plot_off", 32'(bus.vga_plot), 32'd0);
      $display("tb: overlay abort checked at cycle %0d", cyc);

      // ---- asynchronous reset mid E_WAIT ----
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_reset_ctrl", 32'({bus.layer_go, logic_go, inc_enable, erase_phase, busy, frame_done, overrun}), 32'd0);
      chk("async_reset_pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0 || bus.layer_go !== 3'b000) seen = 1;
      end
      chk("idle_after_reset", seen, 0);
      $display("tb: async reset checked at cycle %0d", cyc);

      // ---- tick overrun and back-to-back frames ----
      bus.layer_done = 3'b111;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("overrun_frame_go0", 32'(evt()), 32'b00100);
      repeat (9) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("overrun_after_first_tick", 32'(overrun), 32'd0);
      repeat (8) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("overrun_after_second_tick", 32'(overrun), 32'd1);
      wait_fd(60, ok);
      chk("overrun_frame_done", ok, 1);
      @(negedge clk);
      chk("back_to_back_go0", 32'(evt()), 32'b00100);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      wait_fd(60, ok);
      chk("second_frame_done", ok, 1);
      repeat (5) @(negedge clk);
      chk("no_third_frame", 32'(busy), 32'd0);
      chk("overrun_still_set", 32'(overrun), 32'd1);
      resetn = 1'b0;
      #1;
      chk("overrun_cleared_by_reset", 32'(overrun), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      $display("tb: overrun checked at cycle %0d", cyc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
